// File: rtl/static_cfg_seq.sv
// Static configuration sequencer: serial load, APPLY, settle, then glitch-free commit.
// Optional even-parity check on the loaded word: STATIC_CFG_SEQ_PARITY_CHECK_EN.
module static_cfg_seq #(
    parameter int               WIDTH         = 8,
    parameter int               SETTLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SEN,
    input  logic             SDI,
    input  logic             APPLY,
    output logic             SDO,
    output logic [WIDTH-1:0] CFG,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

`ifdef STATIC_CFG_SEQ_PARITY_CHECK_EN
    localparam int LEN = WIDTH + 1;
`else
    localparam int LEN = WIDTH;
`endif
    localparam int CW = $clog2(LEN + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_FULL    = CW'(LEN);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SETTLE,
        S_COMMIT
    } state_t;

    state_t          state;
    logic [LEN-1:0]  sr;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   scnt;
    logic [CW-1:0]   cnt_inc;
    logic            commit_ok;

    assign cnt_inc = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);

`ifdef STATIC_CFG_SEQ_PARITY_CHECK_EN
    assign commit_ok = ~^sr;
`else
    assign commit_ok = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            sr    <= '0;
            cnt   <= '0;
            scnt  <= '0;
            CFG   <= RESET_VALUE;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // SEN wins over a simultaneous APPLY
                    if (SEN) begin
                        sr    <= {sr[LEN-2:0], SDI};
                        cnt   <= CW'(1);
                        ERR   <= 1'b0;
                        state <= S_SHIFT;
                    end else if (APPLY) begin
                        if (cnt == CNT_FULL) begin
                            scnt  <= SETTLE_LOAD;
                            state <= S_SETTLE;
                        end else begin
                            ERR <= 1'b1;
                            cnt <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    if (SEN) begin
                        sr  <= {sr[LEN-2:0], SDI};
                        cnt <= cnt_inc;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (scnt == '0) begin
                        state <= S_COMMIT;
                    end else begin
                        scnt <= scnt - SW'(1);
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    // The data bits always sit at the top of the shift register
                    if (commit_ok) begin
                        CFG  <= sr[LEN-1 -: WIDTH];
                        DONE <= 1'b1;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY = (state != S_IDLE);
    assign SDO  = sr[LEN-1];

endmodule

// File: tb/tb_static_cfg_seq.sv
// Randomized bench for static_cfg_seq against a transaction-level model.
// Build with STATIC_CFG_SEQ_PARITY_CHECK_EN defined to exercise the parity variant.
module tb_static_cfg_seq;

    localparam int WIDTH = 8;
    localparam int S     = 4;
`ifdef STATIC_CFG_SEQ_PARITY_CHECK_EN
    localparam int LEN = WIDTH + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int LEN = WIDTH;
    localparam bit PAR = 1'b0;
`endif
    localparam int unsigned LMASK = (32'd1 << LEN) - 32'd1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             SEN;
    logic             SDI;
    logic             APPLY;
    logic             SDO;
    logic [WIDTH-1:0] CFG;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    static_cfg_seq #(
        .WIDTH(WIDTH),
        .SETTLE_CYCLES(S),
        .RESET_VALUE('0)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SEN(SEN),
        .SDI(SDI),
        .APPLY(APPLY),
        .SDO(SDO),
        .CFG(CFG),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the last LEN shifted bits, bit count, committed word, error flag
    int unsigned m_sr;
    int unsigned m_cnt;
    int unsigned m_cfg;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_sr  = 0;
        m_cnt = 0;
        m_cfg = 0;
        m_err = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, {31'b0, BUSY}, 0);
        chk({tag, "_cfg"}, {24'b0, CFG}, m_cfg);
        chk({tag, "_err"}, {31'b0, ERR}, {31'b0, m_err});
        chk({tag, "_sdo"}, {31'b0, SDO}, (m_sr >> (LEN - 1)) & 1);
    endtask

    // Shift n bits, bits[n-1] first; noise holds APPLY high throughout
    task automatic shift_bits(input int n, input logic [31:0] bits,
                              input bit noise);
        for (int i = 0; i < n; i++) begin
            SEN   = 1'b1;
            SDI   = bits[n-1-i];
            APPLY = noise;
            tick();
            m_sr = ((m_sr << 1) | {31'b0, bits[n-1-i]}) & LMASK;
            chk("shift_busy", {31'b0, BUSY}, 1);
            chk("shift_err", {31'b0, ERR}, 0);
        end
        m_cnt = (n < LEN) ? n : LEN;
        m_err = 1'b0;
        SEN = 1'b0;
        tick();
        APPLY = 1'b0;
        check_idle("after_shift");
    endtask

    task automatic shift_word(input logic [WIDTH-1:0] d, input bit bad_par,
                              input bit noise);
        logic [31:0] bits;
        if (PAR) begin
            bits = {23'b0, d, (^d) ^ bad_par};
            shift_bits(WIDTH + 1, bits, noise);
        end else begin
            bits = {24'b0, d};
            shift_bits(WIDTH, bits, noise);
        end
    endtask

    task automatic apply_req(input bit noise);
        bit ok;
        APPLY = 1'b1;
        SEN   = 1'b0;
        tick();
        APPLY = 1'b0;
        if (m_cnt != LEN) begin
            m_err = 1'b1;
            m_cnt = 0;
            chk("short_err", {31'b0, ERR}, 1);
            check_idle("short");
            repeat (S + 1) begin
                tick();
                chk("short_done", {31'b0, DONE}, 0);
            end
            return;
        end
        chk("settle_busy0", {31'b0, BUSY}, 1);
        for (int k = 1; k <= S; k++) begin
            if (noise) begin
                APPLY = 1'($urandom_range(0, 1));
                SEN   = 1'($urandom_range(0, 1));
                SDI   = 1'($urandom_range(0, 1));
            end
            tick();
            chk("settle_done", {31'b0, DONE}, 0);
            chk("settle_busy", {31'b0, BUSY}, 1);
            chk("settle_cfg", {24'b0, CFG}, m_cfg);
        end
        APPLY = 1'b0;
        SEN   = 1'b0;
        tick();
        ok = !PAR || ($countones(m_sr) % 2 == 0);
        m_cnt = 0;
        if (ok) begin
            m_cfg = (m_sr >> (LEN - WIDTH)) & 32'hFF;
            chk("commit_done", {31'b0, DONE}, 1);
        end else begin
            m_err = 1'b1;
            chk("parity_done", {31'b0, DONE}, 0);
        end
        check_idle("commit");
        tick();
        chk("done_fall", {31'b0, DONE}, 0);
        check_idle("post_commit");
    endtask

    // Reset sampled k edges after the APPLY edge
    task automatic abort_run(input int k);
        APPLY = 1'b1;
        tick();
        APPLY = 1'b0;
        repeat (k - 1) begin
            tick();
            chk("abort_busy", {31'b0, BUSY}, 1);
            chk("abort_done_pre", {31'b0, DONE}, 0);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_reset();
        chk("abort_done", {31'b0, DONE}, 0);
        check_idle("abort");
        repeat (S + 1) begin
            tick();
            chk("abort_no_done", {31'b0, DONE}, 0);
        end
        check_idle("abort_end");
    endtask

    initial begin
        int op;
        int n;
        RST   = 1'b1;
        SEN   = 1'b0;
        SDI   = 1'b0;
        APPLY = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_done", {31'b0, DONE}, 0);
        check_idle("rst");
        RST = 1'b0;
        tick();
        check_idle("rst_rel");

        shift_word(8'hA5, 1'b0, 1'b0);
        apply_req(1'b0);
        chk("load_a5", {24'b0, CFG}, 32'hA5);
        apply_req(1'b0);
        chk("reapply_err", {31'b0, ERR}, 1);

        shift_bits(5, 32'b10110, 1'b0);
        apply_req(1'b0);
        chk("short_cfg", {24'b0, CFG}, 32'hA5);

        shift_bits(10, 32'b1100111100, 1'b1);
        apply_req(1'b1);
`ifndef STATIC_CFG_SEQ_PARITY_CHECK_EN
        chk("overshift", {24'b0, CFG}, 32'h3C);
`endif

        shift_word(8'h5A, 1'b0, 1'b0);
        abort_run(2);

`ifdef STATIC_CFG_SEQ_PARITY_CHECK_EN
        shift_word(8'h3C, 1'b1, 1'b0);
        apply_req(1'b0);
        chk("par_bad_err", {31'b0, ERR}, 1);
        chk("par_bad_cfg", {24'b0, CFG}, 32'h00);
        shift_word(8'hA5, 1'b0, 1'b0);
        apply_req(1'b0);
        chk("par_good", {24'b0, CFG}, 32'hA5);
`endif

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                n = $urandom_range(1, LEN + 3);
                shift_bits(n, $urandom, 1'($urandom_range(0, 1)));
            end else if (op <= 4) begin
                shift_word(8'($urandom), 1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 1)));
            end else if (op <= 7) begin
                apply_req(1'($urandom_range(0, 1)));
            end else if (op == 8) begin
                if (m_cnt != LEN) shift_word(8'($urandom), 1'b0, 1'b0);
                abort_run($urandom_range(1, S + 1));
            end else begin
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    chk("idle_done", {31'b0, DONE}, 0);
                end
                check_idle("idle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
